// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: receiver FSM state encoding and serial line levels
package serial_rx_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: WIDTH-bit right shift register; ports clk, rst_n (async low), en (shift), sin (into MSB), q (parallel out)
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= {sin, q[WIDTH-1:1]};
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: 1 bit/clk frame receiver (start, WIDTH data LSB first, opt even parity, stop); ports clk, rst_n, din -> data, valid, parity_err, frame_err, busy
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic par_err;
  serial_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == DATA),
    .sin(din),
    .q(sr)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      par_err <= 1'b0;
      data <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (din == START_LEVEL) begin
            state <= DATA;
            cnt <= '0;
          end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: begin
          par_err <= ^sr ^ din;
          state <= STOP;
        end
        STOP: begin
          data <= sr;
          valid <= 1'b1;
          parity_err <= (PARITY_EN != 0) && par_err;
          frame_err <= din != IDLE_LEVEL;
          state <= (din == IDLE_LEVEL) ? IDLE : BREAK;
        end
        BREAK:
          if (din == IDLE_LEVEL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for serial_frame_rx with and without parity
module tb_serial_frame_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic din1 = 1'b1;
  logic din2 = 1'b1;
  logic [7:0] data1, data2;
  logic v1, pe1, fe1, b1, v2, pe2, fe2, b2;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [7:0] d;
    logic pe;
    logic fe;
    int c;
  } exp_t;
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  serial_frame_rx #(.WIDTH(8), .PARITY_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .data(data1), .valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );
  serial_frame_rx #(.WIDTH(8), .PARITY_EN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .data(data2), .valid(v2),
    .parity_err(pe2), .frame_err(fe2), .busy(b2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (v1) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut1 unexpected valid: got data %0h expected no frame", data1);
        end else begin
          e1 = q1.pop_front();
          chk("dut1 data", data1, e1.d);
          chk("dut1 parity_err", pe1, e1.pe);
          chk("dut1 frame_err", fe1, e1.fe);
          chk("dut1 valid cycle", cyc, e1.c);
        end
      end
      if (v2) begin
        if (q2.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut2 unexpected valid: got data %0h expected no frame", data2);
        end else begin
          e2 = q2.pop_front();
          chk("dut2 data", data2, e2.d);
          chk("dut2 parity_err", pe2, e2.pe);
          chk("dut2 frame_err", fe2, e2.fe);
          chk("dut2 valid cycle", cyc, e2.c);
        end
      end
    end
  task automatic send_bit(input bit sel, input logic b);
    if (sel) din2 = b;
    else din1 = b;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par, input logic stop,
                            input logic epe, input logic efe);
    exp_t e;
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (!sel) send_bit(sel, par);
    send_bit(sel, stop);
    e.d = d;
    e.pe = epe;
    e.fe = efe;
    e.c = cyc;
    if (sel) q2.push_back(e);
    else q1.push_back(e);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset data", data1, 8'h00);
    chk("reset valid", v1, 1'b0);
    chk("reset parity_err", pe1, 1'b0);
    chk("reset frame_err", fe1, 1'b0);
    chk("reset busy", b1, 1'b0);
    chk("reset busy2", b2, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_bit(0, 1'b0);
      chk("break busy", b1, 1'b1);
    end
    send_bit(0, 1'b1);
    chk("break exit busy", b1, 1'b0);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    chk("mid-frame busy", b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset data", data1, 8'h00);
    chk("async reset valid", v1, 1'b0);
    chk("async reset busy", b1, 1'b0);
    din1 = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset busy", b1, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) send_bit(0, 1'b1);
    chk("dut1 frames outstanding", q1.size(), 0);
    chk("dut2 frames outstanding", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
